pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Program-counter register and next-PC selector for the single-issue CPU.
- Consumes the word-aligned branch offset produced by the left-shift-by-2 stage (sign-extended immediate << 2) and forms the branch target.
- Also forms the J-type target and accepts register (JR) targets, then updates the PC.
- Holds one pending redirect while fetch is stalled, so no control-flow change is lost.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ALIGN_CHECK, 1, when 1 flag and clear misaligned JR targets; when 0 pass the target unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  fetch stall; PC must not advance while high.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_pc4  in  32  PC+4 of the branch instruction.
- branch_offset  in  32  shifted offset from the shift stage (already << 2).
- jump  in  1  J/JAL this cycle.
- jump_pc4  in  32  PC+4 of the jump instruction.
- jump_index  in  26  instr_index field.
- jr  in  1  JR/JALR this cycle.
- jr_target  in  32  register target.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational from pc.
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- redirect_pending  out  1  a redirect is buffered awaiting stall release.
- misalign  out  1  one-cycle pulse: JR target had nonzero bits [1:0].

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; fetch_valid = 0; redirect_pending = 0; misalign = 0.
  - State = S_BOOT.
  - Internal buffer target = 0.
- Target arithmetic (all mod 2^32, carries discarded):
  - branch target = branch_pc4 + branch_offset.
  - jump target = {jump_pc4[31:28], jump_index, 2'b00}.
  - JR target = jr_target, with bits [1:0] forced to 0 when ALIGN_CHECK = 1.
  - pc_plus4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- Redirect priority when several are asserted together: jr > jump > branch_taken. The lower-priority requests are dropped.
- misalign pulses on the cycle after a JR with jr_target[1:0] != 0 is accepted (applied or buffered), and only when ALIGN_CHECK = 1.
- FSM:
  - S_BOOT: one cycle after reset release. fetch_valid = 0, pc holds RESET_PC, redirect inputs ignored. Always -> S_RUN.
  - S_RUN: fetch_valid = 1.
    - stall = 0 with a redirect: pc <= selected target next edge.
    - stall = 0, no redirect: pc <= pc + 4.
    - stall = 1 with a redirect: buffer <= target, redirect_pending <= 1, pc holds, -> S_HOLD.
    - stall = 1, no redirect: pc holds, stay in S_RUN.
  - S_HOLD: fetch_valid = 1, pc holds while stall = 1.
    - A new redirect while stalled overwrites the buffer (newest wins).
    - Stall drops, no new redirect that cycle: pc <= buffer, redirect_pending <= 0, -> S_RUN.
    - Stall drops together with a new redirect: the new redirect is applied, the buffer is discarded, redirect_pending <= 0, -> S_RUN.
- Latency: one cycle from redirect (with stall low) to the new pc value.
- Reset asserted mid-operation (any state, including S_HOLD) discards the buffer immediately.

Test Plan:
- Reset release -> pc = 32'h0000_3000 with fetch_valid = 0 for 1 cycle. Then 32'h3004 and 32'h3008 on the next edges, fetch_valid = 1.
- branch_taken with branch_pc4 = 32'h3010 and branch_offset = 32'hFFFF_FFF0 (−16), stall = 0 -> next pc = 32'h3000. Same with offset 32'h0000_0100 -> 32'h3110.
- jump with jump_pc4 = 32'h9000_0004 and jump_index = 26'h000_0040 -> next pc = 32'h9000_0100. Assert jr (jr_target = 32'h0000_4000) and branch in the same cycle -> next pc = 32'h0000_4000.
- stall = 1 with jump to 32'h0000_0200: pc holds, redirect_pending = 1. Then a jr to 32'h0000_0300 while still stalled. Release stall -> pc = 32'h0000_0300, redirect_pending = 0.
- Stall drops in the same cycle as a branch to 32'h3400 while the buffer holds 32'h0200 -> pc = 32'h3400. Assert rst_n low while in S_HOLD -> pc = RESET_PC and redirect_pending = 0 immediately.
- jr_target = 32'h0000_5003 with ALIGN_CHECK = 1 -> pc = 32'h0000_5000 and misalign pulses for 1 cycle. With pc = 32'hFFFF_FFFC and no redirect -> next pc = 32'h0000_0000.

Source files
------------

// File: rtl/pc_next_if.sv
// ============================================================================
// pc_next_if : redirect requests in, fetch PC and status out
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_next_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc4;
    logic [31:0] branch_offset;
    logic        jump;
    logic [31:0] jump_pc4;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misalign;

    modport master (
        output stall, branch_taken, branch_pc4, branch_offset,
        output jump, jump_pc4, jump_index, jr, jr_target,
        input  pc, pc_plus4, fetch_valid, redirect_pending, misalign
    );

    modport slave (
        input  stall, branch_taken, branch_pc4, branch_offset,
        input  jump, jump_pc4, jump_index, jr, jr_target,
        output pc, pc_plus4, fetch_valid, redirect_pending, misalign
    );
endinterface

`default_nettype wire

// File: rtl/pc_next_unit.sv
// ============================================================================
// pc_next_unit : PC register with next-PC select and one stalled-redirect buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pc_next_if.slave   bus
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic        mis_q, mis_d;

    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_redir;

    assign w_branch_tgt = bus.branch_pc4 + bus.branch_offset;
    assign w_jump_tgt   = {bus.jump_pc4[31:28], bus.jump_index, 2'b00};
    assign w_jr_tgt     = ALIGN_CHECK ? {bus.jr_target[31:2], 2'b00} : bus.jr_target;
    assign w_pc_plus4   = pc_q + 32'd4;
    assign w_redir      = bus.jr | bus.jump | bus.branch_taken;

    // jr outranks jump, which outranks branch; losers are simply dropped
    always_comb begin
        w_target = w_branch_tgt;
        if (bus.jr)
            w_target = w_jr_tgt;
        else if (bus.jump)
            w_target = w_jump_tgt;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        mis_d   = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                mis_d = ALIGN_CHECK && bus.jr && (bus.jr_target[1:0] != 2'b00);
                if (!bus.stall) begin
                    pc_d = w_redir ? w_target : w_pc_plus4;
                end else if (w_redir) begin
                    buf_d   = w_target;
                    pend_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                mis_d = ALIGN_CHECK && bus.jr && (bus.jr_target[1:0] != 2'b00);
                if (bus.stall) begin
                    if (w_redir)
                        buf_d = w_target;
                end else begin
                    // a redirect arriving with the stall release is newer than the buffer
                    pc_d    = w_redir ? w_target : buf_q;
                    pend_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            buf_q   <= 32'd0;
            pend_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = w_pc_plus4;
    assign bus.fetch_valid      = (state_q != S_BOOT);
    assign bus.redirect_pending = pend_q;
    assign bus.misalign         = mis_q;

endmodule

`default_nettype wire
